vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
Sequences the horizontal and vertical pixel counters of the VGA pipeline and decodes sync, blanking and position from them. Advances one pixel per `clk_en` tick. Supports controlled start/stop at frame boundaries so the scan-out never emits a truncated frame. Sits between the pixel-tick generator and the pixel/colour generator; its outputs drive the VGA connector syncs directly.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
CW, 10, counter width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
clk_en  in  1  pixel tick; all scan advancement is qualified by it
enable  in  1  scan request level; 1 = run, 0 = stop at end of frame
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
video_on  out  1  1 when the current position is inside the active area
pixel_x  out  CW  current horizontal count
pixel_y  out  CW  current vertical count
line_start  out  1  one-clk pulse when pixel_x becomes 0
frame_start  out  1  one-clk pulse when (pixel_x, pixel_y) becomes (0, 0)
busy  out  1  1 whenever state != IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (800 by default); V_TOTAL likewise (525 by default).
- Reset (and IDLE) output values:
  - state = IDLE
  - pixel_x = 0, pixel_y = 0
  - hsync = vsync = ~SYNC_POL (inactive level)
  - video_on = 0, line_start = 0, frame_start = 0, busy = 0
- Reset mid-frame takes effect on the next clk edge regardless of clk_en.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0. On a cycle with enable = 1 and clk_en = 1: go to RUN, keep counters at (0, 0), pulse line_start and frame_start, video_on = 1.
  - RUN: each clk_en advances the counters. If enable = 0 is sampled on any clk, go to DRAIN; counting continues unchanged.
  - DRAIN: counting continues.
    - enable = 1 sampled: return to RUN with no gap or glitch.
    - On the clk_en where (pixel_x, pixel_y) = (H_TOTAL-1, V_TOTAL-1): go to IDLE, counters become (0, 0), all outputs take IDLE values, and no frame_start is emitted.
- Counting (RUN/DRAIN, clk_en = 1):
  - pixel_x increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, pixel_y increments, wrapping V_TOTAL-1 -> 0.
  - With clk_en = 0, counters and all level outputs hold.
- Decoding, applied in the same clk edge as the counter update (zero latency between count and decoded outputs):
  - video_on = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE), and state != IDLE.
  - hsync is active for pixel_x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. [656, 751] by default.
  - vsync is active for pixel_y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. [490, 491]. vsync is asserted across whole lines, including that line's horizontal blanking.
- Pulses:
  - line_start / frame_start are high for exactly one clk after the edge that loads pixel_x = 0 (resp. (0, 0)) in RUN or on entry from IDLE.
  - They deassert on the next clk even if clk_en = 0.
- Simultaneous events:
  - enable falling on the final pixel of a frame while in RUN: go to DRAIN, not IDLE; one further full frame is drained.
  - Drain-completion pixel in DRAIN with enable = 1: return to RUN, wrap normally, emit frame_start.
- Parameter errors: CW too small is flagged by a simulation-time assertion only; no RTL handling.

Test Plan:
- Reset: hold rst = 1 for 3 clks with enable = 1 -> hsync = vsync = 1 (SYNC_POL = 0), video_on = 0, pixel_x = pixel_y = 0, busy = 0.
- Default timing: enable = 1, clk_en every clk, run 420000 clks.
  - hsync low for exactly 96 consecutive ticks, starting at pixel_x = 656, repeating every 800.
  - vsync low exactly for lines 490–491 (1600 ticks).
  - video_on high for 307200 ticks per frame.
  - frame_start pulses every 420000 clks.
- clk_en every 4th clk: the same counts occur over 4x the clks; outputs stable between ticks; pulses remain one clk wide.
- Stop: deassert enable at (100, 200) -> scan continues to (799, 524), then IDLE with busy = 0, counters (0, 0), no further frame_start. Reassert enable -> frame_start on the first clk_en.
- Re-enable during DRAIN at (5, 300) -> state RUN, no gap, frame_start at the next wrap.
- Small parameters (H 4/1/2/1, V 3/1/1/1, CW = 4): H_TOTAL = 8, V_TOTAL = 6; hsync active at pixel_x = 5..6, vsync at pixel_y = 4. rst asserted at (3, 2) -> next clk gives (0, 0), IDLE.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing: horizontal/vertical pixel counters with registered sync, blanking and position.
// Start and stop take effect only at frame boundaries so a truncated frame is never emitted.
module vga_timing_ctrl_chk #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CW      = 10
) (
  input logic clk,
  input logic rst
);

  // Counter width must be able to hold both totals
  always_ff @(posedge clk) begin
    assert (rst || (((64'd1 << CW) >= 64'(H_TOTAL)) && ((64'd1 << CW) >= 64'(V_TOTAL))));
  end

endmodule

module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] x_inc_s, y_inc_s;
  logic          x_last_s, y_last_s, adv_s;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_q, video_d, busy_q, busy_d;
  logic          ls_q, ls_d, fs_q, fs_d;

  assign x_last_s = (x_q == H_LAST);
  assign y_last_s = (y_q == V_LAST);
  assign x_inc_s  = x_last_s ? '0 : (x_q + ONE);
  assign y_inc_s  = x_last_s ? (y_last_s ? '0 : (y_q + ONE)) : y_q;

  // Scan state, counter advance and start pulses
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (enable && clk_en) begin
          state_d = ST_RUN;
          ls_d    = 1'b1;
          fs_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        adv_s = clk_en;
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Only the last pixel of a frame with enable still low ends the scan
        if (clk_en && x_last_s && y_last_s && !enable) begin
          state_d = ST_IDLE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          adv_s   = clk_en;
          state_d = enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
    x_d  = adv_s ? x_inc_s : x_d;
    y_d  = adv_s ? y_inc_s : y_d;
    ls_d = ls_d | (adv_s & x_last_s);
    fs_d = fs_d | (adv_s & x_last_s & y_last_s);
  end

  // Decode from the next counter values so outputs line up with the count
  always_comb begin
    hsync_d = ~SYNC_POL;
    vsync_d = ~SYNC_POL;
    video_d = 1'b0;
    busy_d  = 1'b0;
    if (state_d != ST_IDLE) begin
      busy_d  = 1'b1;
      video_d = (x_d < H_VIS) && (y_d < V_VIS);
      hsync_d = ((x_d >= HS_BEG) && (x_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((y_d >= VS_BEG) && (y_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    end else begin
      busy_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_q <= 1'b0;
      busy_q  <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      busy_q  <= busy_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

  vga_timing_ctrl_chk #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CW      (CW)
  ) u_chk (
    .clk (clk),
    .rst (rst)
  );

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a small-geometry instance (active-high syncs) and a default 640x480 instance,
// both compared every cycle against a tick-index model of the scan.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] ce, en;

  logic       s_hs, s_vs, s_vo, s_ls, s_fs, s_busy;
  logic [3:0] s_x, s_y;
  logic       d_hs, d_vs, d_vo, d_ls, d_fs, d_busy;
  logic [9:0] d_x, d_y;

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .CW(4)
  ) dut_s (
    .clk(clk), .rst(rst), .clk_en(ce[0]), .enable(en[0]),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
    .pixel_x(s_x), .pixel_y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .busy(s_busy)
  );

  vga_timing_ctrl dut_d (
    .clk(clk), .rst(rst), .clk_en(ce[1]), .enable(en[1]),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
    .pixel_x(d_x), .pixel_y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .busy(d_busy)
  );

  // Instance geometry: index 0 = small, 1 = default
  int HA[2] = '{4, 640};
  int HF[2] = '{1, 16};
  int HS[2] = '{2, 96};
  int HB[2] = '{1, 48};
  int VA[2] = '{3, 480};
  int VF[2] = '{1, 10};
  int VS[2] = '{1, 2};
  int VB[2] = '{1, 33};
  bit POL[2] = '{1'b1, 1'b0};

  logic [9:0] o_x[2], o_y[2];
  logic       o_hs[2], o_vs[2], o_vo[2], o_ls[2], o_fs[2], o_busy[2];
  assign o_x[0] = {6'd0, s_x};  assign o_x[1] = d_x;
  assign o_y[0] = {6'd0, s_y};  assign o_y[1] = d_y;
  assign o_hs[0] = s_hs;        assign o_hs[1] = d_hs;
  assign o_vs[0] = s_vs;        assign o_vs[1] = d_vs;
  assign o_vo[0] = s_vo;        assign o_vo[1] = d_vo;
  assign o_ls[0] = s_ls;        assign o_ls[1] = d_ls;
  assign o_fs[0] = s_fs;        assign o_fs[1] = d_fs;
  assign o_busy[0] = s_busy;    assign o_busy[1] = d_busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  // Model: scanning flag, stop-pending flag and linear tick index within the frame
  bit m_act[2], m_drn[2], m_ls[2], m_fs[2];
  int m_t[2];

  function automatic int htot(input int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int vtot(input int k);
    return VA[k] + VF[k] + VS[k] + VB[k];
  endfunction

  function automatic bit hs_act(input int k, input int x);
    return (x >= HA[k] + HF[k]) && (x < HA[k] + HF[k] + HS[k]);
  endfunction

  function automatic bit vs_act(input int k, input int y);
    return (y >= VA[k] + VF[k]) && (y < VA[k] + VF[k] + VS[k]);
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      n = htot(k) * vtot(k);
      m_ls[k] = 1'b0;
      m_fs[k] = 1'b0;
      if (rst) begin
        m_act[k] = 1'b0; m_drn[k] = 1'b0; m_t[k] = 0;
      end else if (!m_act[k]) begin
        if (en[k] && ce[k]) begin
          m_act[k] = 1'b1; m_drn[k] = 1'b0; m_t[k] = 0;
          m_ls[k] = 1'b1; m_fs[k] = 1'b1;
        end
      end else begin
        if (ce[k]) begin
          if (m_drn[k] && !en[k] && m_t[k] == n - 1) begin
            m_act[k] = 1'b0; m_drn[k] = 1'b0; m_t[k] = 0;
          end else begin
            m_t[k]  = (m_t[k] + 1) % n;
            m_ls[k] = (m_t[k] % htot(k)) == 0;
            m_fs[k] = (m_t[k] == 0);
          end
        end
        if (m_act[k]) m_drn[k] = !en[k];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        int ex, ey;
        bit eh, ev;
        ex = m_act[k] ? (m_t[k] % htot(k)) : 0;
        ey = m_act[k] ? (m_t[k] / htot(k)) : 0;
        eh = (m_act[k] && hs_act(k, ex)) ? POL[k] : !POL[k];
        ev = (m_act[k] && vs_act(k, ey)) ? POL[k] : !POL[k];
        chk("pixel_x", k, int'(o_x[k]), ex);
        chk("pixel_y", k, int'(o_y[k]), ey);
        chk("hsync", k, int'(o_hs[k]), int'(eh));
        chk("vsync", k, int'(o_vs[k]), int'(ev));
        chk("video_on", k, int'(o_vo[k]), int'(m_act[k] && ex < HA[k] && ey < VA[k]));
        chk("line_start", k, int'(o_ls[k]), int'(m_ls[k]));
        chk("frame_start", k, int'(o_fs[k]), int'(m_fs[k]));
        chk("busy", k, int'(o_busy[k]), int'(m_act[k]));
      end
    end
  end

  task automatic wait_pos(input int x, input int y, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(s_x) == x && int'(s_y) == y) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wait_pos_reached", 0, int'(ok), 1);
  endtask

  initial begin
    int c_dhs, c_dvo, c_sfs, c_dls, c_svs, n, fsc, pw_err;
    bit prev_fs;
    rst = 1'b1; ce = 2'b11; en = 2'b11;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_drn[k] = 1'b0; m_ls[k] = 1'b0; m_fs[k] = 1'b0; m_t[k] = 0;
    end

    // Pin the model's decode against hand-computed windows
    chk("pin_hs655", 1, int'(hs_act(1, 655)), 0);
    chk("pin_hs656", 1, int'(hs_act(1, 656)), 1);
    chk("pin_hs751", 1, int'(hs_act(1, 751)), 1);
    chk("pin_hs752", 1, int'(hs_act(1, 752)), 0);
    chk("pin_vs490", 1, int'(vs_act(1, 490)), 1);
    chk("pin_vs491", 1, int'(vs_act(1, 491)), 1);
    chk("pin_vs492", 1, int'(vs_act(1, 492)), 0);
    chk("pin_hs4", 0, int'(hs_act(0, 4)), 0);
    chk("pin_hs5", 0, int'(hs_act(0, 5)), 1);
    chk("pin_hs6", 0, int'(hs_act(0, 6)), 1);
    chk("pin_hs7", 0, int'(hs_act(0, 7)), 0);
    chk("pin_vs3", 0, int'(vs_act(0, 3)), 0);
    chk("pin_vs4", 0, int'(vs_act(0, 4)), 1);
    chk("pin_totals", 1, htot(1) * vtot(1), 420000);
    chk("pin_small_totals", 0, htot(0) * 100 + vtot(0), 806);

    // Reset held for 3 clocks with enable high
    step(); cmp_on = 1'b1;
    step(); step();
    chk("rst_hsync", 1, int'(d_hs), 1);
    chk("rst_vsync", 1, int'(d_vs), 1);
    chk("rst_video", 1, int'(d_vo), 0);
    chk("rst_x", 1, int'(d_x), 0);
    chk("rst_y", 1, int'(d_y), 0);
    chk("rst_busy", 1, int'(d_busy), 0);
    chk("rst_hsync_pol1", 0, int'(s_hs), 0);

    // Free run, clk_en every clock
    rst = 1'b0;
    c_dhs = 0; c_dvo = 0; c_sfs = 0; c_dls = 0; c_svs = 0;
    for (int i = 0; i < 1700; i++) begin
      step();
      if (!d_hs) c_dhs++;
      if (d_vo) c_dvo++;
      if (s_fs) c_sfs++;
      if (d_ls) c_dls++;
      if (s_vs) c_svs++;
    end
    chk("dflt_hsync_ticks", 1, c_dhs, 192);
    chk("dflt_video_ticks", 1, c_dvo, 1380);
    chk("dflt_line_starts", 1, c_dls, 3);
    chk("small_frame_starts", 0, c_sfs, 36);
    chk("small_vsync_ticks", 0, c_svs, 280);

    // clk_en on roughly one clock in four; pulses must stay one clock wide
    pw_err = 0; prev_fs = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      ce[0] = ($urandom_range(0, 3) == 0);
      ce[1] = ($urandom_range(0, 3) == 0);
      step();
      if (s_fs && prev_fs) pw_err++;
      prev_fs = s_fs;
    end
    chk("pulse_width", 0, pw_err, 0);

    // Stop at (1,2): drains to the end of the frame without a frame_start
    ce = 2'b11;
    wait_pos(1, 2, 100);
    en[0] = 1'b0;
    n = 0; fsc = 0;
    while (s_busy && n < 100) begin
      step(); n++;
      if (s_fs) fsc++;
    end
    chk("drain_len", 0, n, 31);
    chk("drain_frame_starts", 0, fsc, 0);
    step(); step(); step();
    chk("idle_x", 0, int'(s_x), 0);
    chk("idle_y", 0, int'(s_y), 0);
    en[0] = 1'b1; ce[0] = 1'b0;
    step(); step(); step();
    chk("idle_wait_tick", 0, int'(s_busy), 0);
    ce[0] = 1'b1;
    step();
    chk("restart_fs", 0, int'(s_fs), 1);
    chk("restart_video", 0, int'(s_vo), 1);

    // Re-enable while draining: scan continues, frame_start at the next wrap
    wait_pos(5, 3, 100);
    en[0] = 1'b0;
    step(); step(); step();
    en[0] = 1'b1;
    n = 0;
    while (!s_fs && n < 100) begin
      step(); n++;
    end
    chk("reenable_fs_delay", 0, n, 16);

    // Enable drops on the last pixel in RUN: wrap, then one full frame drained
    wait_pos(7, 5, 100);
    en[0] = 1'b0;
    step();
    chk("last_pixel_fs", 0, int'(s_fs), 1);
    n = 1;
    while (s_busy && n < 200) begin
      step(); n++;
    end
    chk("full_drain_len", 0, n, 49);

    // Reset mid-frame at (3,2) with clk_en low
    en[0] = 1'b1;
    wait_pos(3, 2, 100);
    rst = 1'b1; ce = 2'b00;
    step();
    chk("midrst_x", 0, int'(s_x), 0);
    chk("midrst_y", 0, int'(s_y), 0);
    chk("midrst_busy", 0, int'(s_busy), 0);
    chk("midrst_dflt_busy", 1, int'(d_busy), 0);
    rst = 1'b0; ce = 2'b11;

    // Randomized enable / clk_en / reset traffic
    for (int i = 0; i < 6000; i++) begin
      ce[0] = 1'($urandom_range(0, 1));
      ce[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 499) == 0) en[1] = ~en[1];
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 1'b0;
    step();
    cmp_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
